// File: rtl/decoder_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : decoder_n_seq
// Brief    : Registered N-to-2**N one-hot decoder. It has a sweep mode that
//            steps a single set bit from D[0] up to D[2**N-1], one bit per
//            clock.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_n_seq #(
  parameter int N = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      x,
  input  logic              en,
  input  logic              scan_start,
  input  logic              scan_abort,
  output logic [2**N-1:0]   D,
  output logic              busy,
  output logic              scan_done
);

  localparam int            W       = 2**N;
  localparam logic [N-1:0]  CNT_MAX = '1;

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_SCAN  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [W-1:0] d_q, d_d;
  logic         done_q, done_d;
  logic [N-1:0] cnt_inc;
  logic         cnt_last;

  // Returns a vector with exactly one bit set, at position idx.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
    return {{(W-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Next sweep position. The terminal cycle is the one that shows the top
  // output bit. cnt never wraps because a sweep always ends at CNT_MAX.
  always_comb begin
    cnt_inc  = cnt_q + N'(1);
    cnt_last = (cnt_q == CNT_MAX);
  end

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start request is seen only in IDLE. In SCAN, the
  // terminal cycle takes priority over an abort, so an abort then has no
  // additional effect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (cnt_last || scan_abort) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. Every branch assigns either onehot()
  // or zero to d_d, so D can never have more than one bit set.
  always_comb begin
    cnt_d  = '0;
    d_d    = '0;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          d_d = onehot('0);
        end else if (en) begin
          d_d = onehot(x);
        end
      end
      S_SCAN: begin
        if (cnt_last) begin
          // The sweep has ended. Decode resumes on this same edge.
          if (en) begin
            d_d = onehot(x);
          end
        end else if (scan_abort) begin
          // An aborted sweep gives one all-zero cycle and no done pulse.
          d_d = '0;
        end else begin
          cnt_d  = cnt_inc;
          d_d    = onehot(cnt_inc);
          done_d = (cnt_inc == CNT_MAX);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Registered decode output, sweep counter and done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      d_q    <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      d_q    <= d_d;
      done_q <= done_d;
    end
  end

  // Drive the ports directly from the registers.
  always_comb begin
    D         = d_q;
    busy      = (state_q == S_SCAN);
    scan_done = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_n_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_n_seq
// Brief    : Directed self-checking bench for decoder_n_seq. It instantiates
//            the design with N = 1, 2, 3 and 5. All instances share the
//            clock, reset and control inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_n_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        scan_start;
  logic        scan_abort;
  logic [0:0]  x1;
  logic [1:0]  x2;
  logic [2:0]  x3;
  logic [4:0]  x5;
  logic [1:0]  D1;
  logic [3:0]  D2;
  logic [7:0]  D3;
  logic [31:0] D5;
  logic        busy1, busy2, busy3, busy5;
  logic        done1, done2, done3, done5;

  int vectors    = 0;
  int miscompares = 0;
  int done5_cnt  = 0;

  decoder_n_seq #(.N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .en(en), .scan_start(scan_start),
    .scan_abort(scan_abort), .D(D1), .busy(busy1), .scan_done(done1)
  );
  decoder_n_seq #(.N(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .en(en), .scan_start(scan_start),
    .scan_abort(scan_abort), .D(D2), .busy(busy2), .scan_done(done2)
  );
  decoder_n_seq #(.N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x3), .en(en), .scan_start(scan_start),
    .scan_abort(scan_abort), .D(D3), .busy(busy3), .scan_done(done3)
  );
  decoder_n_seq #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .x(x5), .en(en), .scan_start(scan_start),
    .scan_abort(scan_abort), .D(D5), .busy(busy5), .scan_done(done5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then settle past the edge and check at-most-one-hot.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0_D1", 32'($onehot0(D1)), 32'd1);
    chk("onehot0_D2", 32'($onehot0(D2)), 32'd1);
    chk("onehot0_D3", 32'($onehot0(D3)), 32'd1);
    chk("onehot0_D5", 32'($onehot0(D5)), 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; scan_start = 1'b0; scan_abort = 1'b0;
    x1 = '0; x2 = '0; x3 = '0; x5 = '0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state, reached before any clock edge.
    chk("rst_D2",    32'(D2),    32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    chk("rst_done2", 32'(done2), 32'h0);
    chk("rst_D5",    32'(D5),    32'h0);
    #1 rst_n = 1'b1;

    // Idle decode, N=2.
    en = 1'b1; x2 = 2'b10; step();
    chk("dec_x2",    32'(D2),    32'h4);
    chk("dec_busy",  32'(busy2), 32'h0);
    en = 1'b0; step();
    chk("dec_en0",   32'(D2),    32'h0);
    en = 1'b1; x2 = 2'd3; step();
    chk("dec_x3",    32'(D2),    32'h8);
    x2 = 2'd0; step();
    chk("dec_x0",    32'(D2),    32'h1);

    // Full sweep, N=2.
    x2 = 2'd1; scan_start = 1'b1; step(); scan_start = 1'b0;
    chk("sw_D0", 32'(D2), 32'h1); chk("sw_b0", 32'(busy2), 32'h1); chk("sw_d0", 32'(done2), 32'h0);
    step();
    chk("sw_D1", 32'(D2), 32'h2); chk("sw_b1", 32'(busy2), 32'h1); chk("sw_d1", 32'(done2), 32'h0);
    step();
    chk("sw_D2", 32'(D2), 32'h4); chk("sw_b2", 32'(busy2), 32'h1); chk("sw_d2", 32'(done2), 32'h0);
    step();
    chk("sw_D3", 32'(D2), 32'h8); chk("sw_b3", 32'(busy2), 32'h1); chk("sw_d3", 32'(done2), 32'h1);
    step();
    chk("sw_end_D", 32'(D2), 32'h2); chk("sw_end_b", 32'(busy2), 32'h0); chk("sw_end_d", 32'(done2), 32'h0);

    // Start overrides decode; a second start during the sweep is ignored.
    x2 = 2'd3; scan_start = 1'b1; step();
    chk("ov_D0", 32'(D2), 32'h1);
    step(); scan_start = 1'b0;
    chk("ov_D1", 32'(D2), 32'h2);
    step();
    chk("ov_D2", 32'(D2), 32'h4);
    step();
    chk("ov_D3", 32'(D2), 32'h8); chk("ov_d3", 32'(done2), 32'h1);
    step();
    chk("ov_end_D", 32'(D2), 32'h8); chk("ov_end_b", 32'(busy2), 32'h0);

    // Abort mid-sweep.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    chk("ab_D0", 32'(D2), 32'h1);
    step();
    chk("ab_D1", 32'(D2), 32'h2);
    scan_abort = 1'b1; step(); scan_abort = 1'b0;
    chk("ab_D",  32'(D2),    32'h0);
    chk("ab_b",  32'(busy2), 32'h0);
    chk("ab_d",  32'(done2), 32'h0);
    step();
    chk("ab_resume", 32'(D2), 32'h8);

    // Abort in IDLE is ignored; start wins over abort in IDLE.
    x2 = 2'd1; scan_abort = 1'b1; step();
    chk("ab_idle_D", 32'(D2), 32'h2); chk("ab_idle_b", 32'(busy2), 32'h0);
    scan_start = 1'b1; step(); scan_start = 1'b0; scan_abort = 1'b0;
    chk("sa_D0", 32'(D2), 32'h1); chk("sa_b0", 32'(busy2), 32'h1);
    step();
    chk("sa_D1", 32'(D2), 32'h2);
    step();
    chk("sa_D2", 32'(D2), 32'h4);
    step();
    chk("sa_D3", 32'(D2), 32'h8); chk("sa_d3", 32'(done2), 32'h1);
    // Abort during the terminal cycle has no additional effect.
    scan_abort = 1'b1; step(); scan_abort = 1'b0;
    chk("abt_D", 32'(D2), 32'h2); chk("abt_b", 32'(busy2), 32'h0); chk("abt_d", 32'(done2), 32'h0);
    step();
    chk("abt_d2", 32'(done2), 32'h0);

    // Asynchronous reset mid-sweep, N=3. First clear any sweep still running.
    scan_abort = 1'b1; step(); scan_abort = 1'b0;
    en = 1'b0; step();
    chk("n3_idle_b", 32'(busy3), 32'h0);
    scan_start = 1'b1; step(); scan_start = 1'b0;
    chk("n3_D0", 32'(D3), 32'h01);
    step(); step(); step(); step();
    chk("n3_D4", 32'(D3), 32'h10); chk("n3_b4", 32'(busy3), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("n3_rst_D", 32'(D3),    32'h0);
    chk("n3_rst_b", 32'(busy3), 32'h0);
    chk("n3_rst_d", 32'(done3), 32'h0);
    #2 rst_n = 1'b1;
    en = 1'b1; x3 = 3'd6; step();
    chk("n3_post_D", 32'(D3),    32'h40);
    chk("n3_post_b", 32'(busy3), 32'h0);
    chk("n3_post_d", 32'(done3), 32'h0);

    // Full sweep, N=5, with the N=1 two-cycle sweep alongside.
    x5 = 5'd17; x1 = 1'b1;
    scan_start = 1'b1; step(); scan_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("n5_D",    D5,           32'h1 << i);
      chk("n5_busy", 32'(busy5),   32'h1);
      chk("n5_done", 32'(done5),   (i == 31) ? 32'h1 : 32'h0);
      if (done5) done5_cnt++;
      if (i == 0) begin
        chk("n1_D0", 32'(D1), 32'h1); chk("n1_b0", 32'(busy1), 32'h1); chk("n1_d0", 32'(done1), 32'h0);
      end
      if (i == 1) begin
        chk("n1_D1", 32'(D1), 32'h2); chk("n1_b1", 32'(busy1), 32'h1); chk("n1_d1", 32'(done1), 32'h1);
      end
      if (i == 2) begin
        chk("n1_idle_D", 32'(D1), 32'h2); chk("n1_idle_b", 32'(busy1), 32'h0);
      end
      step();
    end
    chk("n5_done_cnt", 32'(done5_cnt), 32'h1);
    chk("n5_end_b",    32'(busy5),     32'h0);
    chk("n5_end_D",    D5,             32'h0002_0000);
    chk("n5_end_d",    32'(done5),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 Parameter N, default 5: select width; output width is 2**N; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 x  input  N  select code, decode mode.
REQ-005 en  input  1  decode enable; low forces all-zero decode.
REQ-006 scan_start  input  1  single-cycle request to start a sweep of all outputs.
REQ-007 scan_abort  input  1  terminates an active sweep.
REQ-008 D  output  2**N  registered one-hot (or all-zero) decode.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 scan_done  output  1  one-cycle pulse marking the final sweep step.

Function
REQ-011 Block SHALL implement a two-state FSM: IDLE (decode mode) and SCAN (sweep mode).
REQ-012 In IDLE with no scan_start: D SHALL become onehot(x) when en=1, else all-zero; latency exactly 1 clock.
REQ-013 D SHALL never have more than one bit set, in any state or cycle.
REQ-014 IDLE + scan_start=1: FSM SHALL enter SCAN; internal counter cnt SHALL load 0; D SHALL become onehot(0) on the same edge.
REQ-015 scan_start SHALL override en/x in the same IDLE cycle.
REQ-016 In SCAN, each edge SHALL increment cnt by 1 and set D to onehot(cnt+1); x and en SHALL be ignored.
REQ-017 cnt SHALL be N bits wide; terminal value 2**N-1; no wrap inside a sweep.
REQ-018 busy SHALL be 1 in every cycle the FSM is in SCAN, including the cycle D = onehot(2**N-1).
REQ-019 scan_done SHALL be 1 for exactly the one cycle in which D = onehot(2**N-1) and busy=1.
REQ-020 Edge after terminal cycle: FSM SHALL return to IDLE and D SHALL follow REQ-012 using current x/en.
REQ-021 Full sweep SHALL occupy exactly 2**N consecutive busy cycles.
REQ-022 scan_start while in SCAN SHALL be ignored (no restart, no counter reset).
REQ-023 scan_abort in SCAN SHALL return FSM to IDLE on the next edge with D=0 for that cycle, busy=0, scan_done never asserted for that sweep.
REQ-024 scan_abort during the terminal cycle SHALL have no additional effect; scan_done for that cycle already asserted stays a single pulse.
REQ-025 scan_abort in IDLE SHALL be ignored; scan_abort and scan_start together in IDLE: start SHALL win.
REQ-026 N=1 SHALL give a 2-cycle sweep: onehot(0), onehot(1).

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force D=0, busy=0, scan_done=0, cnt=0, FSM=IDLE.
REQ-028 Reset asserted mid-sweep SHALL discard the sweep; after release the block SHALL be in IDLE with no scan_done pulse.
REQ-029 First edge after rst_n release SHALL follow REQ-012 or REQ-014 normally.

Verification
REQ-030 N=2, en=1, x=2'b10 -> next cycle D=4'b0100; en=0 -> next cycle D=4'b0000.
REQ-031 N=2, scan_start pulse -> D = 0001,0010,0100,1000 on four consecutive cycles, busy=1 all four, scan_done=1 only with 1000, then D=onehot(x)/0.
REQ-032 N=2, scan_start with en=1, x=3 same cycle -> D=0001 (scan wins); second scan_start on cycle 2 -> sequence unchanged.
REQ-033 N=2, scan_abort while D=0010 -> next cycle D=0000, busy=0, no scan_done.
REQ-034 N=3, rst_n pulsed low asynchronously while D=00010000 -> D=0, busy=0 before next edge; after release, idle decode resumes.
REQ-035 N=5, full sweep -> 32 busy cycles, one-hot checker never fails, exactly one scan_done.
